// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_sweep_pkg;

    localparam int NUM_IN  = 4;
    localparam int NUM_VEC = 16;
    localparam int CNT_W   = 4;

    localparam logic [NUM_VEC-1:0] EXP_DEFAULT = 16'h4A32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that holds each vector for its settle time.
module tt_settle_timer
    import tt_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Walks all 16 vectors into a 4-input gate, samples its output after a settle
// hold, and compares the measured truth table against an expected one.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int unsigned         SETTLE      = 2,
    parameter logic [NUM_VEC-1:0]  EXP_DEFAULT = tt_sweep_pkg::EXP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               use_ext_exp,
    input  logic [NUM_VEC-1:0] ext_exp,
    output logic [NUM_IN-1:0]  dut_in,
    input  logic               dut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] tt_meas,
    output logic [NUM_VEC-1:0] mismatch,
    output logic [4:0]         fail_count
);

    state_t             state;
    logic [NUM_IN-1:0]  idx;
    logic [NUM_VEC-1:0] exp_lat;

    logic       accept;
    logic       running;
    logic       timer_zero;
    logic       sample;
    logic       last;
    logic       miss_bit;
    logic [4:0] fail_next;

    assign accept    = start && (state != RUN);
    assign running   = (state == RUN) && !abort;
    assign sample    = running && timer_zero;
    assign last      = (idx == NUM_IN'(NUM_VEC - 1));
    assign miss_bit  = dut_out ^ exp_lat[idx];
    assign fail_next = fail_count + {4'd0, miss_bit};

    tt_settle_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept || (sample && !last)),
        .en    (running),
        .value (CNT_W'(SETTLE)),
        .zero  (timer_zero)
    );

    // dut_in is a plain register so the gate never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            exp_lat    <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            tt_meas    <= '0;
            mismatch   <= '0;
            fail_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        exp_lat    <= use_ext_exp ? ext_exp : EXP_DEFAULT;
                        tt_meas    <= '0;
                        mismatch   <= '0;
                        fail_count <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        idx        <= '0;
                        dut_in     <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state  <= IDLE;
                        dut_in <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b0;
                    end else if (timer_zero) begin
                        tt_meas[idx]  <= dut_out;
                        mismatch[idx] <= miss_bit;
                        fail_count    <= fail_next;
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_next == 5'd0);
                        end else begin
                            idx    <= idx + 1'b1;
                            dut_in <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
